// File: rtl/decoy_pkg.sv
// Shared encodings for the multi-level decoy generator: FSM states, source
// modes, and the symbols-per-RNG-word helper.
package decoy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PPS = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RNG   = 2'd0;
    localparam logic [1:0] MODE_SEQ   = 2'd1;
    localparam logic [1:0] MODE_FIXED = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    function automatic int calc_spw(input int rng_w, input int lvl_w);
        return rng_w / lvl_w;
    endfunction

endpackage

// File: rtl/decoy_rng_fifo.sv
// Synchronous show-ahead FIFO buffering RNG words; dout is the head word
// whenever empty is low.
module decoy_rng_fifo #(
    parameter int W  = 4,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/decoy_level_gen.sv
// Multi-level decoy symbol generator: one intensity symbol per transmit slot,
// sourced from buffered RNG words, a sequence RAM or a fixed level, PPS-aligned.
module decoy_level_gen
    import decoy_pkg::*;
#(
    parameter int RNG_W     = 4,
    parameter int LVL_W     = 2,
    parameter int FIFO_AW   = 3,
    parameter int SEQ_AW    = 6,
    parameter int PULSE_LEN = 3
) (
    input  logic              clk240,
    input  logic              decoy_rst,
    input  logic              pps_i,
    input  logic              arm,
    input  logic [1:0]        mode,
    input  logic [LVL_W-1:0]  fixed_level,
    input  logic [SEQ_AW-1:0] seq_max_addr,
    input  logic              seq_wr_en,
    input  logic [SEQ_AW-1:0] seq_wr_addr,
    input  logic [LVL_W-1:0]  seq_wr_data,
    input  logic [RNG_W-1:0]  rng_value,
    input  logic              rng_value_valid,
    input  logic              rd_en_4,
    input  logic              err_clr,
    output logic [LVL_W-1:0]  decoy_level,
    output logic              decoy_valid,
    output logic              decoy_signal,
    output logic              underrun,
    output logic              overflow,
    output logic [1:0]        state_o
);
    localparam int SPW   = calc_spw(RNG_W, LVL_W);
    localparam int SUB_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SPW - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_LEN - 1);

    state_t             st;
    logic               pps_q;
    logic [1:0]         mode_q;
    logic [SUB_W-1:0]   sub_idx;
    logic [SEQ_AW-1:0]  seq_addr;
    logic [SEQ_AW-1:0]  seq_next;
    logic [SEQ_AW-1:0]  seq_rd_addr;
    logic               seq_rd_en;
    logic [LVL_W-1:0]   seq_q;
    logic [LVL_W-1:0]   ram [1 << SEQ_AW];
    logic [CNT_W-1:0]   pulse_rem;
    logic [RNG_W-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               run_entry;
    logic               slot;
    logic               rng_slot;
    logic               seq_slot;
    logic [LVL_W-1:0]   rng_sym;
    logic [LVL_W-1:0]   sym;
    logic               underrun_set;
    logic               overflow_set;

    // rd_en_4 is a bare strobe with no back-pressure: every strobe seen in RUN
    // while armed is one slot and always yields decoy_valid on the next cycle.
    assign run_entry = (st == ST_WAIT_PPS) && arm && pps_i && !pps_q;
    assign slot      = (st == ST_RUN) && arm && rd_en_4;
    assign rng_slot  = slot && (mode_q == MODE_RNG);
    assign seq_slot  = slot && (mode_q == MODE_SEQ);

    assign rng_sym  = LVL_W'(fifo_dout >> (LVL_W * sub_idx));
    assign fifo_pop = rng_slot && !fifo_empty && (sub_idx == SUB_LAST);

    assign seq_next    = (seq_addr >= seq_max_addr) ? '0 : seq_addr + 1'b1;
    assign seq_rd_en   = run_entry || seq_slot;
    assign seq_rd_addr = run_entry ? '0 : seq_next;

    assign underrun_set = rng_slot && fifo_empty;
    assign overflow_set = rng_value_valid && fifo_full && !fifo_pop;
    assign state_o      = st;

    always_comb begin
        sym = '0;
        case (mode_q)
            MODE_RNG:   sym = fifo_empty ? '0 : rng_sym;
            MODE_SEQ:   sym = seq_q;
            MODE_FIXED: sym = fixed_level;
            default:    sym = '0;
        endcase
    end

    decoy_rng_fifo #(.W(RNG_W), .AW(FIFO_AW)) u_fifo (
        .clk   (clk240),
        .flush (decoy_rst),
        .push  (rng_value_valid),
        .pop   (fifo_pop),
        .din   (rng_value),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read is only issued when the address moves, so a write to the
    // already-prefetched address stays invisible until the next re-read.
    always_ff @(posedge clk240) begin
        if (seq_wr_en) ram[seq_wr_addr] <= seq_wr_data;
        if (seq_rd_en) seq_q <= ram[seq_rd_addr];
    end

    always_ff @(posedge clk240) begin
        if (decoy_rst) begin
            st           <= ST_IDLE;
            pps_q        <= 1'b0;
            mode_q       <= MODE_RNG;
            sub_idx      <= '0;
            seq_addr     <= '0;
            pulse_rem    <= '0;
            decoy_level  <= '0;
            decoy_valid  <= 1'b0;
            decoy_signal <= 1'b0;
            underrun     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            pps_q       <= pps_i;
            decoy_valid <= slot;
            underrun    <= underrun_set || (underrun && !err_clr);
            overflow    <= overflow_set || (overflow && !err_clr);

            case (st)
                ST_WAIT_PPS: begin
                    if (!arm) begin
                        st <= ST_IDLE;
                    end else if (run_entry) begin
                        st       <= ST_RUN;
                        mode_q   <= mode;
                        sub_idx  <= '0;
                        seq_addr <= '0;
                    end
                end
                ST_RUN: begin
                    if (!arm) st <= ST_IDLE;
                end
                default: begin
                    st <= arm ? ST_WAIT_PPS : ST_IDLE;
                end
            endcase

            if (slot) decoy_level <= sym;
            if (rng_slot && !fifo_empty)
                sub_idx <= (sub_idx == SUB_LAST) ? '0 : sub_idx + 1'b1;
            if (seq_slot) seq_addr <= seq_next;

            if (slot) begin
                decoy_signal <= (sym != '0);
                pulse_rem    <= (sym != '0) ? CNT_RELOAD : '0;
            end else if ((st == ST_RUN) && arm && (pulse_rem != '0)) begin
                pulse_rem <= pulse_rem - 1'b1;
            end else begin
                decoy_signal <= 1'b0;
                pulse_rem    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decoy_level_gen.sv
// Directed bench for decoy_level_gen: a cycle-level behavioural model checked
// every cycle, plus literal level lists and pulse-length counts per scenario.
module tb_decoy_level_gen;
    localparam int RNG_W     = 4;
    localparam int LVL_W     = 2;
    localparam int PULSE_LEN = 3;
    localparam int SPW       = RNG_W / LVL_W;
    localparam int FIFO_D    = 8;

    logic             clk240 = 1'b0;
    logic             decoy_rst = 1'b1;
    logic             pps_i = 1'b0;
    logic             arm = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [LVL_W-1:0] fixed_level = '0;
    logic [5:0]       seq_max_addr = '0;
    logic             seq_wr_en = 1'b0;
    logic [5:0]       seq_wr_addr = '0;
    logic [LVL_W-1:0] seq_wr_data = '0;
    logic [RNG_W-1:0] rng_value = '0;
    logic             rng_value_valid = 1'b0;
    logic             rd_en_4 = 1'b0;
    logic             err_clr = 1'b0;
    logic [LVL_W-1:0] decoy_level;
    logic             decoy_valid;
    logic             decoy_signal;
    logic             underrun;
    logic             overflow;
    logic [1:0]       state_o;

    int n_chk = 0;
    int n_err = 0;

    decoy_level_gen dut (
        .clk240          (clk240),
        .decoy_rst       (decoy_rst),
        .pps_i           (pps_i),
        .arm             (arm),
        .mode            (mode),
        .fixed_level     (fixed_level),
        .seq_max_addr    (seq_max_addr),
        .seq_wr_en       (seq_wr_en),
        .seq_wr_addr     (seq_wr_addr),
        .seq_wr_data     (seq_wr_data),
        .rng_value       (rng_value),
        .rng_value_valid (rng_value_valid),
        .rd_en_4         (rd_en_4),
        .err_clr         (err_clr),
        .decoy_level     (decoy_level),
        .decoy_valid     (decoy_valid),
        .decoy_signal    (decoy_signal),
        .underrun        (underrun),
        .overflow        (overflow),
        .state_o         (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk240 = ~clk240;

    // ---------------- behavioural model ----------------
    int m_state = 0;       // 0 idle, 1 waiting for PPS, 2 running
    bit m_pps_prev = 0;
    int m_mode = 0;
    int m_sub = 0;
    int m_addr = 0;
    int m_prefetch = 0;
    int m_ram [64];
    int fq [$];
    int m_left = 0;        // remaining high cycles of decoy_signal
    int m_level = 0;
    bit m_valid = 0;
    bit m_under = 0;
    bit m_over = 0;
    bit chk_en = 0;

    always @(posedge clk240) begin : model
        bit slot;
        bit u_ev;
        bit o_ev;
        int s;
        if (decoy_rst) begin
            m_state = 0; m_pps_prev = 0; m_mode = 0; m_sub = 0; m_addr = 0;
            fq.delete(); m_left = 0; m_level = 0; m_valid = 0;
            m_under = 0; m_over = 0; chk_en = 1;
        end else begin
            slot = (m_state == 2) && arm && rd_en_4;
            u_ev = 0; o_ev = 0; s = 0;
            if (slot) begin
                case (m_mode)
                    0: begin
                        if (fq.size() == 0) begin
                            u_ev = 1;
                        end else begin
                            s = (fq[0] >> (LVL_W * m_sub)) % (1 << LVL_W);
                            m_sub++;
                            if (m_sub == SPW) begin
                                void'(fq.pop_front());
                                m_sub = 0;
                            end
                        end
                    end
                    1: begin
                        s = m_prefetch;
                        m_addr = (m_addr >= int'(seq_max_addr)) ? 0 : m_addr + 1;
                        m_prefetch = m_ram[m_addr];
                    end
                    2: s = int'(fixed_level);
                    default: s = 0;
                endcase
            end
            if (rng_value_valid) begin
                if (fq.size() < FIFO_D) fq.push_back(int'(rng_value));
                else o_ev = 1;
            end
            m_valid = slot;
            if (slot) begin
                m_level = s;
                m_left = (s != 0) ? PULSE_LEN : 0;
            end else if (m_state == 2 && arm && m_left > 0) begin
                m_left--;
            end else begin
                m_left = 0;
            end
            m_under = u_ev || (m_under && !err_clr);
            m_over  = o_ev || (m_over && !err_clr);
            case (m_state)
                0: if (arm) m_state = 1;
                1: begin
                    if (!arm) m_state = 0;
                    else if (pps_i && !m_pps_prev) begin
                        m_state = 2; m_mode = int'(mode); m_sub = 0;
                        m_addr = 0; m_prefetch = m_ram[0];
                    end
                end
                default: if (!arm) m_state = 0;
            endcase
            m_pps_prev = pps_i;
        end
        if (seq_wr_en) m_ram[seq_wr_addr] = int'(seq_wr_data);
    end

    // ---------------- scoreboard ----------------
    logic [LVL_W-1:0] exp_q [$];
    logic [LVL_W-1:0] got_q [$];
    int sig_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk240) begin
        if (decoy_valid) got_q.push_back(decoy_level);
        if (decoy_signal) sig_cnt++;
        if (chk_en) begin
            check("cyc_level", int'(decoy_level), m_level);
            check("cyc_valid", int'(decoy_valid), int'(m_valid));
            check("cyc_signal", int'(decoy_signal), int'(m_left > 0));
            check("cyc_underrun", int'(underrun), int'(m_under));
            check("cyc_overflow", int'(overflow), int'(m_over));
            check("cyc_state", int'(state_o), m_state);
        end
    end

    task automatic check_levels(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk240);
            #1;
        end
    endtask

    task automatic do_reset();
        decoy_rst = 1'b1;
        tick(2);
        decoy_rst = 1'b0;
    endtask

    task automatic pps_pulse();
        pps_i = 1'b1;
        tick(1);
        pps_i = 1'b0;
        tick(1);
    endtask

    task automatic do_slot(input int gap);
        rd_en_4 = 1'b1;
        tick(1);
        rd_en_4 = 1'b0;
        tick(gap - 1);
    endtask

    task automatic push_word(input logic [RNG_W-1:0] w);
        rng_value = w;
        rng_value_valid = 1'b1;
        tick(1);
        rng_value_valid = 1'b0;
    endtask

    task automatic ram_write(input int a, input int d);
        seq_wr_addr = 6'(a);
        seq_wr_data = LVL_W'(d);
        seq_wr_en = 1'b1;
        tick(1);
        seq_wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic load_exp(input int vals [$]);
        foreach (vals[i]) exp_q.push_back(LVL_W'(vals[i]));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        tick(3);
        decoy_rst = 1'b0;
        check("reset_state", int'(state_o), 0);
        check("reset_level", int'(decoy_level), 0);
        check("reset_signal", int'(decoy_signal), 0);

        // FIXED level 2; strobes before PPS are ignored
        mode = 2'd2; fixed_level = 2'd2; arm = 1'b1;
        tick(2);
        check("wait_state", int'(state_o), 1);
        sig_cnt = 0;
        do_slot(3); do_slot(3);
        check("pre_pps_outputs", got_q.size(), 0);
        check("pre_pps_signal", sig_cnt, 0);
        pps_pulse();
        check("run_state", int'(state_o), 2);
        repeat (4) do_slot(5);
        load_exp('{2, 2, 2, 2});
        check_levels("fixed");
        check("fixed_pulse_cycles", sig_cnt, 12);
        arm = 1'b0;
        tick(2);

        // RNG words 1,2,3 consumed LSB symbol first
        do_reset();
        push_word(4'h1); push_word(4'h2); push_word(4'h3);
        mode = 2'd0; arm = 1'b1;
        tick(2);
        pps_pulse();
        sig_cnt = 0;
        repeat (6) do_slot(4);
        load_exp('{1, 0, 2, 0, 3, 0});
        check_levels("rng");
        check("rng_pulse_cycles", sig_cnt, 9);
        check("rng_no_underrun", int'(underrun), 0);

        // empty FIFO at a slot, sticky underrun, set-wins over clear
        do_slot(3);
        load_exp('{0});
        check_levels("rng_empty");
        check("underrun_set", int'(underrun), 1);
        tick(5);
        check("underrun_sticky", int'(underrun), 1);
        pulse_clr();
        check("underrun_cleared", int'(underrun), 0);
        err_clr = 1'b1;
        do_slot(1);
        err_clr = 1'b0;
        tick(1);
        check("underrun_set_wins", int'(underrun), 1);
        pulse_clr();
        got_q.delete();

        // 9 words with no slots: last dropped, overflow sticky
        for (int w = 4; w <= 12; w++) push_word(4'(w));
        tick(1);
        check("overflow_set", int'(overflow), 1);
        pulse_clr();
        check("overflow_cleared", int'(overflow), 0);
        do_slot(3);
        rd_en_4 = 1'b1; rng_value = 4'hD; rng_value_valid = 1'b1;
        tick(1);
        rd_en_4 = 1'b0; rng_value_valid = 1'b0;
        tick(2);
        check("pop_push_full_no_overflow", int'(overflow), 0);
        repeat (16) do_slot(3);
        load_exp('{0, 1, 1, 1, 2, 1, 3, 1, 0, 2, 1, 2, 2, 2, 3, 2, 1, 3});
        check_levels("rng_drain");
        arm = 1'b0;
        tick(2);

        // SEQ mode with wrap at 3, mode change ignored, late RAM write
        ram_write(0, 1); ram_write(1, 2); ram_write(2, 3); ram_write(3, 0);
        seq_max_addr = 6'd3; mode = 2'd1; arm = 1'b1;
        tick(2);
        pps_pulse();
        repeat (10) do_slot(3);
        mode = 2'd2; fixed_level = 2'd3;
        ram_write(2, 1);
        repeat (4) do_slot(3);
        rd_en_4 = 1'b1;
        tick(1);
        rd_en_4 = 1'b0; arm = 1'b0;
        tick(1);
        check("arm_drop_signal", int'(decoy_signal), 0);
        check("arm_drop_state", int'(state_o), 0);
        load_exp('{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 1});
        check_levels("seq");

        // re-arm restarts at address 0; reset mid-pulse truncates
        mode = 2'd1; arm = 1'b1;
        tick(3);
        do_slot(3);
        check("rearm_waits", got_q.size(), 0);
        pps_pulse();
        do_slot(4);
        rd_en_4 = 1'b1;
        tick(1);
        rd_en_4 = 1'b0;
        tick(1);
        decoy_rst = 1'b1;
        tick(1);
        check("rst_signal", int'(decoy_signal), 0);
        check("rst_state", int'(state_o), 0);
        check("rst_level", int'(decoy_level), 0);
        decoy_rst = 1'b0;
        tick(2);
        pps_pulse();
        do_slot(4);
        load_exp('{1, 2, 1});
        check_levels("rearm_seq");

        // seq_max_addr = 0 repeats address 0
        arm = 1'b0;
        tick(2);
        seq_max_addr = 6'd0; arm = 1'b1;
        tick(2);
        pps_pulse();
        repeat (3) do_slot(3);
        load_exp('{1, 1, 1});
        check_levels("seq_max0");

        // retrigger on close nonzero slots, zero slot cancels
        arm = 1'b0;
        tick(2);
        mode = 2'd2; fixed_level = 2'd3; arm = 1'b1;
        tick(2);
        pps_pulse();
        sig_cnt = 0;
        repeat (3) do_slot(2);
        fixed_level = 2'd0;
        do_slot(5);
        load_exp('{3, 3, 3, 0});
        check_levels("retrigger");
        check("retrigger_pulse_cycles", sig_cnt, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decoy_level_gen.md
Name: decoy_level_gen

Overview:
- Parametrised successor to the single-level decoy pulse generator. Emits one multi-level decoy intensity symbol per transmit slot, selected from a buffered RNG stream, a programmable sequence RAM, or a fixed level.
- Start is aligned to PPS.
- Sits between the fast-DAC RNG source and the decoy output delay/driver stage, in the clk240 domain.

Parameters:
RNG_W, 4, width of incoming RNG word; must be a multiple of LVL_W
LVL_W, 2, bits per decoy level symbol (2^LVL_W intensity levels, 0 = vacuum/off)
FIFO_AW, 3, log2 depth of RNG word FIFO (8 words)
SEQ_AW, 6, log2 depth of sequence RAM (64 symbols)
PULSE_LEN, 3, decoy_signal high time in clk240 cycles, >=1

Ports:
clk240 in 1 sole clock
decoy_rst in 1 reset, synchronous, active-high
pps_i in 1 PPS, already synchronous to clk240
arm in 1 level; high = run from next PPS rising edge
mode in 2 0 RNG, 1 SEQ, 2 FIXED, 3 OFF
fixed_level in LVL_W level used in FIXED mode
seq_max_addr in SEQ_AW last sequence address before wrap
seq_wr_en in 1 sequence RAM write strobe
seq_wr_addr in SEQ_AW RAM write address
seq_wr_data in LVL_W RAM write data
rng_value in RNG_W RNG word
rng_value_valid in 1 RNG word strobe
rd_en_4 in 1 slot strobe, one symbol consumed per strobe, min spacing 2 cycles
err_clr in 1 clears sticky flags
decoy_level out LVL_W symbol for current slot
decoy_valid out 1 one-cycle strobe with decoy_level
decoy_signal out 1 drive pulse
underrun out 1 sticky, slot with empty FIFO in RNG mode
overflow out 1 sticky, RNG word dropped on full FIFO
state_o out 2 FSM state, for debug

Behaviour:
- Reset (decoy_rst=1 at clk240 edge):
  - All outputs 0; state IDLE.
  - FIFO flushed; symbol sub-index and sequence address set to 0.
  - RAM contents retained. Reset mid-pulse truncates decoy_signal the next cycle.
- FSM:
  - IDLE(0): goes to WAIT_PPS(1) when arm=1.
  - WAIT_PPS: goes to RUN(2) on a PPS rising edge (pps_i=1 and registered previous pps_i=0); goes to IDLE if arm=0.
  - RUN: goes to IDLE on arm=0; decoy_signal/decoy_valid forced 0 from the next cycle.
  - State 3 unused; it decodes to IDLE.
- mode is latched on the WAIT_PPS->RUN transition and held through RUN. Changes during RUN are ignored.
- On RUN entry:
  - Sequence address set to 0.
  - Sub-index set to 0.
  - FIFO is not flushed.
- rd_en_4 outside RUN is ignored. Nothing is consumed.
- Slot, with rd_en_4=1 in RUN at cycle N:
  - decoy_level and decoy_valid=1 registered at cycle N+1 (latency 1).
  - decoy_level holds until the next slot.
- RNG mode:
  - Each word holds SPW=RNG_W/LVL_W symbols, consumed LSB-first.
  - The sub-index increments per slot. The word is popped when the last symbol is used.
  - FIFO empty at a slot: decoy_level=0, decoy_valid=1, underrun set, sub-index unchanged.
- FIFO writes:
  - Push on rng_value_valid when not full.
  - When full with no pop: the word is dropped and overflow is set.
  - Pop and push in the same cycle while full: both are performed.
  - Push to an empty FIFO in the same cycle as a slot: counts as underrun (no bypass).
- SEQ mode:
  - Symbol = RAM[addr]. RAM is synchronous-read and prefetched one cycle after the address changes.
  - addr increments per slot and wraps seq_max_addr -> 0.
  - seq_max_addr=0 repeats address 0.
  - A write to the prefetched address is seen only after the next re-read.
  - Writes are accepted in any state.
- FIXED mode: fixed_level is sampled at the slot.
- OFF mode: level 0.
- decoy_signal:
  - Goes high at N+1 for PULSE_LEN cycles if decoy_level!=0.
  - A new nonzero slot restarts the counter (retrigger).
  - A zero slot cancels the pulse from N+1.
- Sticky flags:
  - Cleared by err_clr or reset.
  - If err_clr and a set event occur in the same cycle, set wins.

Decomposition:
- Shared package decoy_pkg:
  - Mode encodings MODE_RNG/SEQ/FIXED/OFF.
  - State encodings ST_IDLE/WAIT_PPS/RUN.
  - Function computing SPW.
- Sub-module decoy_rng_fifo:
  - Sync FIFO of depth 2^FIFO_AW, RNG_W wide.
  - Ports: push, pop, full, empty, dout, flush.
- Sequence RAM is inferred in the top module.

Test Plan:
- Reset, arm=1, mode=FIXED, fixed_level=2, PPS edge then rd_en_4 every 5 cycles -> decoy_level=2 and decoy_valid one cycle after each strobe; decoy_signal high exactly 3 cycles each time; no output before PPS.
- RNG mode, push words 0x1, 0x2, 0x3 (RNG_W=4, LVL_W=2) -> slot levels 1, 0, 2, 0, 3, 0; decoy_signal only on nonzero slots.
- RNG mode with FIFO empty at first slot -> level 0, underrun=1 and stays 1 until err_clr pulse; push 9 words with no slots -> overflow=1, first 8 retained.
- SEQ mode, RAM[0..3]=1,2,3,0, seq_max_addr=3, 10 slots -> 1,2,3,0,1,2,3,0,1,2.
- arm dropped mid-pulse, then decoy_rst asserted mid-RUN -> decoy_signal low next cycle; state_o=0; re-arm waits for the next PPS edge and restarts sequence at address 0.
- Mode changed from SEQ to FIXED during RUN -> ignored until re-arm; levels continue from sequence.
